dram_ctrl: RTL and testbench

DRAM_CTRL -- requirements
Module: dram_ctrl

---
 rtl/dram_pkg.sv | 35 +++
 rtl/dram_wait_cnt.sv | 22 ++
 rtl/dram_ctrl.sv | 153 +++++++++++++++
 tb/tb_dram_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// dram_pkg: shared types, command encodings and address geometry for dram_ctrl.
// Contents: state_t FSM enum, cmd_t command bundle {CSn,RASn,CASn,WEn},
//           ROW_W/COL_W/ADDR_W constants, max3 helper for counter sizing.
package dram_pkg;
  localparam int ROW_W  = 11;
  localparam int COL_W  = 10;
  localparam int ADDR_W = ROW_W + COL_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ACT,
    S_CMD,
    S_RD_WAIT,
    S_WR_WAIT
  } state_t;

  typedef struct packed {
    logic       csn;
    logic       rasn;
    logic       casn;
    logic [3:0] wen;
  } cmd_t;

  localparam cmd_t CMD_NOP = '{csn: 1'b1, rasn: 1'b1, casn: 1'b1, wen: 4'hF};
  localparam cmd_t CMD_PRE = '{csn: 1'b0, rasn: 1'b0, casn: 1'b1, wen: 4'h0};
  localparam cmd_t CMD_ACT = '{csn: 1'b0, rasn: 1'b0, casn: 1'b1, wen: 4'hF};
  localparam cmd_t CMD_RW  = '{csn: 1'b0, rasn: 1'b1, casn: 1'b0, wen: 4'hF};

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/dram_wait_cnt.sv
// dram_wait_cnt: loadable down-counter that stops at zero and flags it.
// Ports: clk/rst_n clock and async active-low reset; i_load/i_val reload the
//        count; o_done is high while the count is zero.
module dram_wait_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_done
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  assign o_done = (r_cnt == '0);
endmodule

// File: rtl/dram_ctrl.sv
// dram_ctrl: single-outstanding-request DRAM controller with an open-row policy.
// Ports: dram_clk/dram_rst_n clock and async active-low reset;
//        req_* request handshake (valid/ready, write, 21-bit word address,
//        data, byte strobes); rsp_valid/rsp_rdata read response pulse;
//        wr_done write completion pulse; DRAM_* command/address/data pins,
//        DRAM_Q/DRAM_valid read data return.
module dram_ctrl
  import dram_pkg::*;
#(
  parameter int T_RCD = 5,
  parameter int T_RP  = 5,
  parameter int T_WR  = 5
) (
  input  logic              dram_clk,
  input  logic              dram_rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              wr_done,
  output logic              DRAM_CSn,
  output logic              DRAM_RASn,
  output logic              DRAM_CASn,
  output logic [3:0]        DRAM_WEn,
  output logic [ROW_W-1:0]  DRAM_A,
  output logic [31:0]       DRAM_D,
  input  logic [31:0]       DRAM_Q,
  input  logic              DRAM_valid
);
  localparam int CNT_W = $clog2(max3(T_RP, T_RCD, T_WR) + 1);

  state_t             r_state, w_next;
  logic               r_entry;
  logic               r_row_open;
  logic [ROW_W-1:0]   r_open_row;
  logic               r_write;
  logic [ADDR_W-1:0]  r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_wstrb;
  logic               r_rsp_valid;
  logic [31:0]        r_rsp_rdata;
  logic [31:0]        r_d;
  logic               w_accept;
  logic               w_done;
  logic               w_load;
  logic [CNT_W-1:0]   w_load_val;
  logic [ROW_W-1:0]   w_req_row;
  logic               w_wr_cmd;
  cmd_t               w_cmd;
  logic [ROW_W-1:0]   w_a;

  // Ready is gated by reset so it reads 0 while reset is held.
  assign req_ready = dram_rst_n && (r_state == S_IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_req_row = req_addr[ADDR_W-1:COL_W];

  // Counter reloads on every state change; a state holding the value N-1 on
  // entry lasts exactly N cycles before done lets it move on.
  assign w_load     = (w_next != r_state);
  assign w_load_val = (w_next == S_PRE)     ? CNT_W'(T_RP - 1)  :
                      (w_next == S_ACT)     ? CNT_W'(T_RCD - 1) :
                      (w_next == S_WR_WAIT) ? CNT_W'(T_WR - 1)  : '0;

  dram_wait_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk    (dram_clk),
    .rst_n  (dram_rst_n),
    .i_load (w_load),
    .i_val  (w_load_val),
    .o_done (w_done)
  );

  always_ff @(posedge dram_clk or negedge dram_rst_n) begin
    if (!dram_rst_n) begin
      r_state <= S_IDLE;
      r_entry <= 1'b0;
    end else begin
      r_state <= w_next;
      r_entry <= w_load;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = (r_row_open && r_open_row == w_req_row) ? S_CMD :
                                         r_row_open ? S_PRE : S_ACT;
      S_PRE:     if (w_done) w_next = S_ACT;
      S_ACT:     if (w_done) w_next = S_CMD;
      S_CMD:     w_next = r_write ? S_WR_WAIT : S_RD_WAIT;
      S_RD_WAIT: if (DRAM_valid) w_next = S_IDLE;
      S_WR_WAIT: if (w_done) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Commands are issued only in the entry cycle of PRE/ACT; CMD is always one cycle.
  always_comb begin
    w_cmd = CMD_NOP;
    w_a   = '0;
    if (r_entry && r_state == S_PRE) begin
      w_cmd = CMD_PRE;
      w_a   = r_open_row;
    end else if (r_entry && r_state == S_ACT) begin
      w_cmd = CMD_ACT;
      w_a   = r_addr[ADDR_W-1:COL_W];
    end else if (r_state == S_CMD) begin
      w_cmd     = CMD_RW;
      w_cmd.wen = r_write ? ~r_wstrb : 4'hF;
      w_a       = {1'b0, r_addr[COL_W-1:0]};
    end
  end

  assign w_wr_cmd = (r_state == S_CMD) && r_write;
  assign {DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn} = w_cmd;
  assign DRAM_A    = w_a;
  assign DRAM_D    = w_wr_cmd ? r_wdata : r_d;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign wr_done   = (r_state == S_WR_WAIT) && w_done;

  always_ff @(posedge dram_clk or negedge dram_rst_n) begin
    if (!dram_rst_n) begin
      r_row_open  <= 1'b0;
      r_open_row  <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_d         <= '0;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_wstrb <= req_wstrb;
      end
      if (r_entry && r_state == S_PRE) r_row_open <= 1'b0;
      if (r_entry && r_state == S_ACT) begin
        r_row_open <= 1'b1;
        r_open_row <= r_addr[ADDR_W-1:COL_W];
      end
      if (w_wr_cmd) r_d <= r_wdata;
      r_rsp_valid <= (r_state == S_RD_WAIT) && DRAM_valid;
      if (r_state == S_RD_WAIT && DRAM_valid) r_rsp_rdata <= DRAM_Q;
    end
  end
endmodule

// File: tb/tb_dram_ctrl.sv
// tb_dram_ctrl: directed self-checking bench for dram_ctrl.
module tb_dram_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, req_ready, req_write = 0;
  logic [20:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid, wr_done;
  logic [31:0] rsp_rdata;
  logic        DRAM_CSn, DRAM_RASn, DRAM_CASn;
  logic [3:0]  DRAM_WEn;
  logic [10:0] DRAM_A;
  logic [31:0] DRAM_D, DRAM_Q = '0;
  logic        DRAM_valid = 0;

  int pass_n = 0, tot_n = 0, cyc = 0;
  int n_pre = 0, n_act = 0, n_rw = 0, n_rsp = 0, n_wd = 0, n_acc = 0, n_rsp_rdy = 0, n_rsp_acc = 0;
  int pre_t, act_t, rw_t, wd_t;
  logic [10:0] pre_a, act_a, rw_a;
  logic [3:0]  rw_wen;
  logic [31:0] rw_d, rsp_d;

  dram_ctrl dut (
    .dram_clk(clk), .dram_rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .wr_done(wr_done),
    .DRAM_CSn(DRAM_CSn), .DRAM_RASn(DRAM_RASn), .DRAM_CASn(DRAM_CASn),
    .DRAM_WEn(DRAM_WEn), .DRAM_A(DRAM_A), .DRAM_D(DRAM_D),
    .DRAM_Q(DRAM_Q), .DRAM_valid(DRAM_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!DRAM_CSn && !DRAM_RASn && DRAM_CASn && DRAM_WEn == 4'h0) begin n_pre++; pre_t = cyc; pre_a = DRAM_A; end
    if (!DRAM_CSn && !DRAM_RASn && DRAM_CASn && DRAM_WEn == 4'hF) begin n_act++; act_t = cyc; act_a = DRAM_A; end
    if (!DRAM_CSn && DRAM_RASn && !DRAM_CASn) begin n_rw++; rw_t = cyc; rw_a = DRAM_A; rw_wen = DRAM_WEn; rw_d = DRAM_D; end
    if (rsp_valid) begin
      n_rsp++; rsp_d = rsp_rdata;
      if (req_ready) n_rsp_rdy++;
      if (req_ready && req_valid) n_rsp_acc++;
    end
    if (wr_done) begin n_wd++; wd_t = cyc; end
    if (req_valid && req_ready) n_acc++;
  end

  task automatic send(input logic w, input logic [20:0] a, input logic [31:0] d, input logic [3:0] s);
    logic r = 0;
    req_write = w; req_addr = a; req_wdata = d; req_wstrb = s; req_valid = 1;
    for (int k = 0; k < 100; k++) begin r = req_ready; @(posedge clk); #1; if (r) break; end
    req_valid = 0; req_write = ~w; req_addr = '1; req_wdata = '1; req_wstrb = '1;
    if (!r) begin tot_n++; $display("FAIL send_timeout addr=%h never accepted", a); end
  endtask

  task automatic respond(input int b_rw, input logic [31:0] q);
    int b_rsp = n_rsp;
    for (int k = 0; k < 100 && n_rw == b_rw; k++) @(posedge clk);
    #1;
    if (n_rw == b_rw) begin tot_n++; $display("FAIL rd_cmd_timeout got=0 READ want=1"); end
    DRAM_Q = q; DRAM_valid = 1;
    @(posedge clk); #1;
    DRAM_valid = 0; DRAM_Q = '0;
    for (int k = 0; k < 100 && n_rsp == b_rsp; k++) @(posedge clk);
    #1;
    if (n_rsp == b_rsp) begin tot_n++; $display("FAIL rsp_timeout got=0 rsp want=1"); end
  endtask

  task automatic wait_wd(input int b_wd);
    for (int k = 0; k < 100 && n_wd == b_wd; k++) @(posedge clk);
    #1;
    if (n_wd == b_wd) begin tot_n++; $display("FAIL wr_done_timeout got=0 want=1"); end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    tot_n++; if (req_ready !== 1'b0) $display("FAIL rst_ready got=%b want=0", req_ready); else pass_n++;
    tot_n++; if ({DRAM_CSn, DRAM_RASn, DRAM_CASn} !== 3'b111) $display("FAIL rst_strobes got=%b want=111", {DRAM_CSn, DRAM_RASn, DRAM_CASn}); else pass_n++;
    tot_n++; if (DRAM_WEn !== 4'hF) $display("FAIL rst_wen got=%h want=f", DRAM_WEn); else pass_n++;
    tot_n++; if (DRAM_A !== 11'h0) $display("FAIL rst_a got=%h want=0", DRAM_A); else pass_n++;
    tot_n++; if (DRAM_D !== 32'h0) $display("FAIL rst_d got=%h want=0", DRAM_D); else pass_n++;
    tot_n++; if ({rsp_valid, wr_done, rsp_rdata} !== 34'h0) $display("FAIL rst_rsp got=%b%b%h want=0", rsp_valid, wr_done, rsp_rdata); else pass_n++;
    rst_n = 1;
    #1;
    tot_n++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready got=%b want=1", req_ready); else pass_n++;
  endtask

  task automatic test_cold_read;
    int b_act = n_act, b_pre = n_pre, b_rw = n_rw, b_rsp = n_rsp;
    send(0, 21'h040005, 32'h0, 4'h0);
    respond(b_rw, 32'hDEADBEEF);
    tot_n++; if (n_act - b_act !== 1) $display("FAIL cold_act_count got=%0d want=1", n_act - b_act); else pass_n++;
    tot_n++; if (n_pre !== b_pre) $display("FAIL cold_pre_count got=%0d want=0", n_pre - b_pre); else pass_n++;
    tot_n++; if (act_a !== 11'h100) $display("FAIL cold_act_a got=%h want=100", act_a); else pass_n++;
    tot_n++; if (rw_t - act_t !== 5) $display("FAIL cold_trcd got=%0d want=5", rw_t - act_t); else pass_n++;
    tot_n++; if (rw_a !== 11'h005 || rw_wen !== 4'hF) $display("FAIL cold_read_cmd got=a%h/we%h want=a005/wef", rw_a, rw_wen); else pass_n++;
    tot_n++; if (n_rsp - b_rsp !== 1 || rsp_d !== 32'hDEADBEEF) $display("FAIL cold_rsp got=%0d/%h want=1/deadbeef", n_rsp - b_rsp, rsp_d); else pass_n++;
    tot_n++; if (rsp_valid !== 1'b0) $display("FAIL cold_rsp_pulse got=%b want=0", rsp_valid); else pass_n++;
  endtask

  task automatic test_row_hit;
    int b_act = n_act, b_pre = n_pre, b_rw = n_rw, b_rsp = n_rsp, b_wd = n_wd;
    send(1, 21'h040007, 32'h12345678, 4'b0011);
    @(posedge clk); #1;
    DRAM_valid = 1; DRAM_Q = 32'hBAD0BAD0;
    @(posedge clk); #1;
    DRAM_valid = 0; DRAM_Q = '0;
    wait_wd(b_wd);
    repeat (2) @(posedge clk);
    #1;
    tot_n++; if (n_act !== b_act || n_pre !== b_pre) $display("FAIL hit_no_act got=act%0d/pre%0d want=0/0", n_act - b_act, n_pre - b_pre); else pass_n++;
    tot_n++; if (n_rw - b_rw !== 1) $display("FAIL hit_cmd_count got=%0d want=1", n_rw - b_rw); else pass_n++;
    tot_n++; if (rw_wen !== 4'b1100) $display("FAIL hit_wen got=%b want=1100", rw_wen); else pass_n++;
    tot_n++; if (rw_a !== 11'h007) $display("FAIL hit_a got=%h want=007", rw_a); else pass_n++;
    tot_n++; if (rw_d !== 32'h12345678) $display("FAIL hit_d got=%h want=12345678", rw_d); else pass_n++;
    tot_n++; if (wd_t - rw_t !== 5) $display("FAIL hit_twr got=%0d want=5", wd_t - rw_t); else pass_n++;
    tot_n++; if (n_wd - b_wd !== 1) $display("FAIL hit_wd_count got=%0d want=1", n_wd - b_wd); else pass_n++;
    tot_n++; if (n_rsp !== b_rsp) $display("FAIL hit_stray_rsp got=%0d want=0", n_rsp - b_rsp); else pass_n++;
  endtask

  task automatic test_row_miss;
    int b_act = n_act, b_pre = n_pre, b_rw = n_rw;
    send(0, 21'h080000, 32'h0, 4'h0);
    respond(b_rw, 32'hCAFEF00D);
    tot_n++; if (n_pre - b_pre !== 1 || pre_a !== 11'h100) $display("FAIL miss_pre got=%0d/%h want=1/100", n_pre - b_pre, pre_a); else pass_n++;
    tot_n++; if (n_act - b_act !== 1 || act_a !== 11'h200) $display("FAIL miss_act got=%0d/%h want=1/200", n_act - b_act, act_a); else pass_n++;
    tot_n++; if (act_t - pre_t !== 5) $display("FAIL miss_trp got=%0d want=5", act_t - pre_t); else pass_n++;
    tot_n++; if (rw_t - act_t !== 5) $display("FAIL miss_trcd got=%0d want=5", rw_t - act_t); else pass_n++;
    tot_n++; if (rw_a !== 11'h000 || rw_wen !== 4'hF) $display("FAIL miss_read got=a%h/we%h want=a000/wef", rw_a, rw_wen); else pass_n++;
    tot_n++; if (rsp_d !== 32'hCAFEF00D) $display("FAIL miss_rdata got=%h want=cafef00d", rsp_d); else pass_n++;
  endtask

  task automatic test_back_to_back;
    int b_act = n_act, b_pre = n_pre, b_rsp = n_rsp, b_acc = n_acc, b_rdy = n_rsp_rdy, b_sacc = n_rsp_acc;
    fork
      begin
        req_write = 0; req_valid = 1;
        for (int i = 0; i < 4; i++) begin
          logic r = 0;
          req_addr = 21'h0C0000 + 21'(i);
          for (int k = 0; k < 200; k++) begin r = req_ready; @(posedge clk); #1; if (r) break; end
          if (!r) begin tot_n++; $display("FAIL b2b_accept_timeout req=%0d", i); end
        end
        req_valid = 0;
      end
      begin
        for (int i = 0; i < 4; i++) respond(n_rw, 32'h10000000 + 32'(i));
      end
    join
    repeat (3) @(posedge clk);
    #1;
    tot_n++; if (n_rsp - b_rsp !== 4) $display("FAIL b2b_rsp_count got=%0d want=4", n_rsp - b_rsp); else pass_n++;
    tot_n++; if (n_act - b_act !== 1 || n_pre - b_pre !== 1) $display("FAIL b2b_act_pre got=%0d/%0d want=1/1", n_act - b_act, n_pre - b_pre); else pass_n++;
    tot_n++; if (n_acc - b_acc !== 4) $display("FAIL b2b_accepts got=%0d want=4", n_acc - b_acc); else pass_n++;
    tot_n++; if (n_rsp_rdy - b_rdy !== 4) $display("FAIL b2b_ready_on_rsp got=%0d want=4", n_rsp_rdy - b_rdy); else pass_n++;
    tot_n++; if (n_rsp_acc - b_sacc !== 3) $display("FAIL b2b_accept_on_rsp got=%0d want=3", n_rsp_acc - b_sacc); else pass_n++;
    tot_n++; if (rsp_d !== 32'h10000003) $display("FAIL b2b_last_rdata got=%h want=10000003", rsp_d); else pass_n++;
  endtask

  task automatic test_zero_strobe;
    int b_act = n_act, b_rw = n_rw, b_wd = n_wd;
    send(1, 21'h0C0009, 32'h55AA55AA, 4'h0);
    wait_wd(b_wd);
    tot_n++; if (n_rw - b_rw !== 1 || rw_wen !== 4'hF) $display("FAIL zs_write got=%0d/%h want=1/f", n_rw - b_rw, rw_wen); else pass_n++;
    tot_n++; if (rw_a !== 11'h009 || rw_d !== 32'h55AA55AA) $display("FAIL zs_a_d got=%h/%h want=009/55aa55aa", rw_a, rw_d); else pass_n++;
    tot_n++; if (n_wd - b_wd !== 1 || n_act !== b_act) $display("FAIL zs_wd_act got=%0d/%0d want=1/0", n_wd - b_wd, n_act - b_act); else pass_n++;
  endtask

  task automatic test_reset_mid;
    int b_rw = n_rw, b_rsp;
    int b_act, b_pre;
    send(0, 21'h040001, 32'h0, 4'h0);
    for (int k = 0; k < 100 && n_rw == b_rw; k++) @(posedge clk);
    #1;
    if (n_rw == b_rw) begin tot_n++; $display("FAIL rm_read_timeout got=0 want=1"); end
    rst_n = 0;
    #1;
    tot_n++; if (req_ready !== 1'b0) $display("FAIL rm_ready got=%b want=0", req_ready); else pass_n++;
    tot_n++; if ({DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn} !== 7'h7F || DRAM_A !== 11'h0) $display("FAIL rm_cmd got=%b%b%b%h/%h want=111f/000", DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A); else pass_n++;
    tot_n++; if (DRAM_D !== 32'h0 || rsp_rdata !== 32'h0 || rsp_valid !== 1'b0) $display("FAIL rm_data got=%h/%h/%b want=0/0/0", DRAM_D, rsp_rdata, rsp_valid); else pass_n++;
    b_rsp = n_rsp;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    #1;
    tot_n++; if (req_ready !== 1'b1) $display("FAIL rm_release_ready got=%b want=1", req_ready); else pass_n++;
    @(posedge clk); #1;
    DRAM_valid = 1; DRAM_Q = 32'h77777777;
    @(posedge clk); #1;
    DRAM_valid = 0; DRAM_Q = '0;
    repeat (3) @(posedge clk);
    #1;
    tot_n++; if (n_rsp !== b_rsp) $display("FAIL rm_no_rsp got=%0d want=0", n_rsp - b_rsp); else pass_n++;
    b_act = n_act; b_pre = n_pre; b_rw = n_rw;
    send(0, 21'h040002, 32'h0, 4'h0);
    respond(b_rw, 32'h0BADF00D);
    tot_n++; if (n_act - b_act !== 1 || act_a !== 11'h100) $display("FAIL rm_reopen_act got=%0d/%h want=1/100", n_act - b_act, act_a); else pass_n++;
    tot_n++; if (n_pre !== b_pre) $display("FAIL rm_no_pre got=%0d want=0", n_pre - b_pre); else pass_n++;
    tot_n++; if (rsp_d !== 32'h0BADF00D) $display("FAIL rm_rdata got=%h want=0badf00d", rsp_d); else pass_n++;
  endtask

  initial begin
    test_reset;
    test_cold_read;
    test_row_hit;
    test_row_miss;
    test_back_to_back;
    test_zero_strobe;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
